stream_downsize: RTL and testbench
==================================

Name: stream_downsize

Overview:
- Converts a wide AXI-Stream-style beat into a sequence of narrow beats. Each wide beat holds T_DATA_RATIO lanes of T_DATA_WIDTH bits, plus a per-lane keep mask and a last flag.
- It is the inverse of the team's stream upsizer. It sits on the egress side of wide datapaths that feed narrow consumers.
- Only kept lanes are emitted, in ascending lane order. Packet boundaries are preserved via m_last_o.

Parameters:
- T_DATA_WIDTH, 4: bits per narrow word (one lane).
- T_DATA_RATIO, 2: lanes per wide beat. Must be >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_data_i  in  [T_DATA_WIDTH-1:0] x [T_DATA_RATIO-1:0]  wide beat lanes. Lane 0 is the first in time.
- s_keep_i  in  T_DATA_RATIO  per-lane valid mask.
- s_last_i  in  1  wide beat ends the packet.
- s_valid_i  in  1  wide beat valid.
- s_ready_o  out  1  downsizer can accept a wide beat.
- m_data_o  out  T_DATA_WIDTH  narrow word.
- m_last_o  out  1  narrow word ends the packet.
- m_valid_o  out  1  narrow word valid.
- m_ready_i  in  1  downstream accepts the narrow word.

Behaviour:
- Handshakes:
  - Transfer on a side occurs when valid && ready at posedge clk.
  - m_valid_o, once high, stays high with m_data_o and m_last_o stable until m_ready_i is high.
- State machine has two states, IDLE and SEND.
- IDLE:
  - s_ready_o = 1, m_valid_o = 0.
  - On s_valid_i: capture data into buf, s_keep_i into keep_q, s_last_i into last_q.
  - If s_keep_i != 0, go to SEND. Else stay in IDLE; the beat is consumed and dropped.
- SEND:
  - ptr = index of the lowest set bit of keep_q.
  - m_valid_o = 1, m_data_o = buf[ptr].
  - m_last_o = last_q && (keep_q has no set bit above ptr).
  - On m_ready_i: clear keep_q[ptr].
  - If that was the final kept lane, the next state is IDLE, unless a new beat is accepted the same cycle.
- Back-to-back operation:
  - s_ready_o = (state==IDLE) || (m_valid_o && m_ready_i && final lane).
  - This combinational path from m_ready_i to s_ready_o is permitted.
  - On a simultaneous final-lane pop and new-beat accept, load the new beat and stay in SEND if its keep != 0, else go to IDLE.
- Throughput and latency:
  - Full keep gives T_DATA_RATIO narrow words per wide beat with zero bubbles.
  - The first narrow word is valid the cycle after the wide beat is accepted (1-cycle latency).
- Keep handling:
  - Sparse keep (e.g. 4'b1010) emits lanes 1 then 3 only, with no idle cycles between them.
  - A zero-keep beat with last=1 is dropped, including its last. Upstream must not generate one; it is a documented limitation.
- Reset (rst_n=0 at posedge):
  - state=IDLE, keep_q=0, last_q=0, buf=0.
  - Outputs: m_valid_o=0, m_last_o=0, m_data_o=0.
  - s_ready_o is forced to 0 while rst_n=0 and is 1 from the first cycle after reset release.
  - Reset mid-packet discards the held beat; no partial output follows.
- Widths:
  - ptr is $clog2(T_DATA_RATIO) bits.
  - No arithmetic overflow; keep_q only ever clears bits.

Decomposition:
- Package stream_pkg: state enum (IDLE, SEND) and a localparam for the ptr width helper.
- One sub-module, stream_lane_select: purely combinational lowest-set-bit priority encoder.
  - Inputs: keep mask.
  - Outputs: ptr, any, last_lane (no higher bits set).
  - Reusable by the upsizer for keep generation.

Test Plan:
- Defaults, full keep:
  - Stimulus: s_data={4'hB,4'hA}, keep=2'b11, last=1, m_ready_i=1 constant.
  - Response: cycle+1 A (last=0), cycle+2 B (last=1). s_ready_o=1 in the B cycle, allowing the next beat with no gap.
- Sparse keep, T_DATA_RATIO=4:
  - Stimulus: data={D,C,B,A}, keep=4'b1010, last=1.
  - Response: outputs B then D. m_last_o only on D. s_ready_o=0 during B.
- Backpressure:
  - Stimulus: full-keep beat {2,1}; hold m_ready_i=0 for 3 cycles after m_valid_o rises.
  - Response: m_data_o=1 stable and m_valid_o held for 3 cycles, then 1 and 2 complete. s_ready_o=0 throughout.
- Zero keep:
  - Stimulus: keep=2'b00, last=0, followed by keep=2'b01 with data lane0=7, last=1.
  - Response: first beat produces no output. Then a single word 7 with m_last_o=1.
- Multi-beat packet:
  - Stimulus: beats {2,1} last=0, then {4,3} last=1, with random m_ready_i.
  - Response: sequence 1,2,3,4 in order; m_last_o only on 4; no duplicates or drops.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 after the first lane of a 2-lane beat is sent.
  - Response: m_valid_o=0 next cycle; s_ready_o=0 during reset, then 1. The remaining lane is never emitted.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
package stream_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  // Lane-index width; at least one bit so a degenerate ratio still elaborates.
  function automatic int unsigned ptr_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_lane_select.sv
// Lowest-set-bit priority encoder over a lane keep mask; also flags whether the
// selected lane is the highest kept one.
module stream_lane_select
  import stream_pkg::*;
#(
  parameter int unsigned Ratio = 2,
  parameter int unsigned PtrW  = ptr_width(Ratio)
) (
  input  logic [Ratio-1:0] keep_i,
  output logic [PtrW-1:0]  ptr_o,
  output logic             any_o,
  output logic             last_lane_o
);

  logic found;

  always_comb begin
    ptr_o       = '0;
    last_lane_o = 1'b1;
    found       = 1'b0;
    for (int i = 0; i < Ratio; i++) begin
      if (keep_i[i]) begin
        if (!found) begin
          ptr_o = PtrW'(i);
          found = 1'b1;
        end else begin
          last_lane_o = 1'b0;
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each wide beat in
// ascending order, one narrow word per cycle, preserving packet boundaries.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]  s_data_i,
  input  logic [T_DATA_RATIO-1:0]                    s_keep_i,
  input  logic                                       s_last_i,
  input  logic                                       s_valid_i,
  output logic                                       s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                    m_data_o,
  output logic                                       m_last_o,
  output logic                                       m_valid_o,
  input  logic                                       m_ready_i
);

  localparam int unsigned PtrW = ptr_width(T_DATA_RATIO);

  state_e                                    state_q;
  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] buf_q;
  logic [T_DATA_RATIO-1:0]                   keep_q;
  logic                                      last_q;

  logic [PtrW-1:0] lane_ptr;
  logic            lane_any;
  logic            lane_last;
  logic            pop;

  stream_lane_select #(
    .Ratio(T_DATA_RATIO),
    .PtrW (PtrW)
  ) u_lane_select (
    .keep_i     (keep_q),
    .ptr_o      (lane_ptr),
    .any_o      (lane_any),
    .last_lane_o(lane_last)
  );

  always_comb begin
    m_valid_o = (state_q == StSend) && lane_any;
    m_data_o  = m_valid_o ? buf_q[lane_ptr] : '0;
    m_last_o  = m_valid_o && last_q && lane_last;
    pop       = m_valid_o && m_ready_i;
    // Popping the final lane frees the buffer in the same cycle.
    s_ready_o = rst_n && ((state_q == StIdle) || (pop && lane_last));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (s_valid_i && s_ready_o) begin
      // A zero-keep beat is consumed and dropped, last flag included.
      buf_q   <= s_data_i;
      keep_q  <= s_keep_i;
      last_q  <= s_last_i;
      state_q <= (|s_keep_i) ? StSend : StIdle;
    end else if (pop) begin
      keep_q[lane_ptr] <= 1'b0;
      if (lane_last) begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize with a queue-based reference model.
module tb_stream_downsize;

  localparam int unsigned W = 4;
  localparam int unsigned R = 4;

  logic               clk;
  logic               rst_n;
  logic [R-1:0][W-1:0] s_data_i;
  logic [R-1:0]       s_keep_i;
  logic               s_last_i;
  logic               s_valid_i;
  logic               s_ready_o;
  logic [W-1:0]       m_data_o;
  logic               m_last_o;
  logic               m_valid_o;
  logic               m_ready_i;

  stream_downsize #(
    .T_DATA_WIDTH(W),
    .T_DATA_RATIO(R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data_i (s_data_i),
    .s_keep_i (s_keep_i),
    .s_last_i (s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  word_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  mon_en = 1'b1;
  logic  rand_ready = 1'b0;

  // Reference: every kept lane becomes one word, lowest lane first; the word
  // carries last only if the beat is last and no higher lane is kept.
  function automatic void model_push(input logic [R-1:0][W-1:0] d, input logic [R-1:0] k,
                                     input logic l);
    word_t w;
    for (int i = 0; i < R; i++) begin
      if (k[i]) begin
        w.data = d[i];
        w.last = l && ((k >> (i + 1)) == 0);
        exp_q.push_back(w);
      end
    end
  endfunction

  // Output monitor: scoreboard on every narrow handshake, plus hold stability.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [W-1:0] pd = '0;
  logic         pl = 1'b0;
  word_t        e;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (pv && !pr) begin
        vectors++;
        if (m_valid_o !== 1'b1 || m_data_o !== pd || m_last_o !== pl) begin
          miscompares++;
          $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   m_valid_o, m_data_o, m_last_o, pd, pl);
        end
      end
      if (m_valid_o && m_ready_i) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: unexpected word data=%h last=%b", m_data_o, m_last_o);
        end else begin
          e = exp_q.pop_front();
          if (m_data_o !== e.data || m_last_o !== e.last) begin
            miscompares++;
            $display("FAIL scoreboard: data=%h last=%b, required data=%h last=%b",
                     m_data_o, m_last_o, e.data, e.last);
          end
        end
      end
    end
    pv = mon_en && rst_n && m_valid_o;
    pr = m_ready_i;
    pd = m_data_o;
    pl = m_last_o;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [R-1:0][W-1:0] d, input logic [R-1:0] k, input logic l);
    int n = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_keep_i  = k;
    s_last_i  = l;
    @(negedge clk);
    while (!s_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: s_ready_o=%b, required 1", s_ready_o);
    end else begin
      model_push(d, k, l);
    end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || m_valid_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || m_valid_o) begin
      miscompares++;
      $display("FAIL drain_timeout: pending=%0d valid=%b, required 0 0", exp_q.size(), m_valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid_i = 1'b0;
    s_data_i = '0;
    s_keep_i = '0;
    s_last_i = 1'b0;
    m_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (s_ready_o !== 1'b0 || m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b last=%b data=%h, required 0 0 0 0",
               s_ready_o, m_valid_o, m_last_o, m_data_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", s_ready_o, m_valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  // Drives one beat with m_ready_i=1 and checks the cycle-exact output train.
  task automatic test_pattern(input string name, input logic [R-1:0][W-1:0] d,
                              input logic [R-1:0] k);
    int cnt = 0;
    int seen = 0;
    logic [W-1:0] lanes[R];
    for (int i = 0; i < R; i++) begin
      if (k[i]) begin
        lanes[cnt] = d[i];
        cnt++;
      end
    end
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = d;
    s_keep_i = k;
    s_last_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_accept: s_ready_o=%b, required 1", name, s_ready_o);
    end
    model_push(d, k, 1'b1);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    for (int j = 0; j < cnt; j++) begin
      @(negedge clk);
      vectors++;
      if (m_valid_o !== 1'b1 || m_data_o !== lanes[j] || m_last_o !== (j == cnt - 1) ||
          s_ready_o !== (j == cnt - 1)) begin
        miscompares++;
        $display("FAIL %s_word%0d: valid=%b data=%h last=%b ready=%b, required 1 %h %b %b",
                 name, j, m_valid_o, m_data_o, m_last_o, s_ready_o, lanes[j],
                 (j == cnt - 1), (j == cnt - 1));
      end
      seen++;
    end
    @(negedge clk);
    vectors++;
    if (m_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_end: valid=%b after %0d words, required 0", name, m_valid_o, seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = 16'h0021;
    s_keep_i = 4'b0011;
    s_last_i = 1'b1;
    @(negedge clk);
    model_push(s_data_i, s_keep_i, s_last_i);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if (m_valid_o !== 1'b1 || m_data_o !== 4'h1 || s_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b, required 1 1 0",
                 j, m_valid_o, m_data_o, s_ready_o);
      end
    end
    @(posedge clk);
    #1;
    m_ready_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_data_o !== 4'h1 || s_ready_o !== 1'b0 || m_last_o !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_first: data=%h ready=%b last=%b, required 1 0 0",
               m_data_o, s_ready_o, m_last_o);
    end
    @(negedge clk);
    vectors++;
    if (m_data_o !== 4'h2 || m_last_o !== 1'b1 || s_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_second: data=%h last=%b ready=%b, required 2 1 1",
               m_data_o, m_last_o, s_ready_o);
    end
    wait_drain();
  endtask

  task automatic test_zero_keep();
    m_ready_i = 1'b1;
    send_beat(16'h00F5, 4'b0000, 1'b0);
    @(negedge clk);
    vectors++;
    if (m_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_keep_drop: valid=%b, required 0", m_valid_o);
    end
    @(posedge clk);
    #1;
    send_beat(16'h0007, 4'b0001, 1'b1);
    @(negedge clk);
    vectors++;
    if (m_valid_o !== 1'b1 || m_data_o !== 4'h7 || m_last_o !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_keep_next: valid=%b data=%h last=%b, required 1 7 1",
               m_valid_o, m_data_o, m_last_o);
    end
    wait_drain();
  endtask

  task automatic test_multi_beat();
    rand_ready = 1'b1;
    send_beat(16'h0021, 4'b0011, 1'b0);
    send_beat(16'h0043, 4'b0011, 1'b1);
    wait_drain();
    rand_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rand_ready = 1'b1;
    for (int b = 0; b < 150; b++) begin
      send_beat(16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready_i = 1'b1;
    mon_en = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = 16'h0065;
    s_keep_i = 4'b0011;
    s_last_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_valid_o !== 1'b1 || m_data_o !== 4'h5) begin
      miscompares++;
      $display("FAIL rmid_first: valid=%b data=%h, required 1 5", m_valid_o, m_data_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_ready_low: s_ready_o=%b, required 0", s_ready_o);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (m_valid_o !== 1'b0 || m_data_o !== '0 || m_last_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_cleared: valid=%b data=%h last=%b, required 0 0 0",
               m_valid_o, m_data_o, m_last_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      vectors++;
      if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL rmid_after%0d: valid=%b ready=%b, required 0 1", j, m_valid_o, s_ready_o);
      end
    end
    @(posedge clk);
    #1;
    exp_q.delete();
    mon_en = 1'b1;
    send_beat(16'h0098, 4'b0011, 1'b1);
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pattern("full_keep", 16'hDCBA, 4'b1111);
    test_pattern("sparse", 16'hDCBA, 4'b1010);
    test_backpressure();
    test_zero_keep();
    test_multi_beat();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
